// File: rtl/mem_arbiter_if.sv
// Bundles the instruction port, data port and downstream (L2) port of the memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] imem_address;
  logic [WIDTH-1:0] imem_wdata;
  logic             imem_read;
  logic             imem_write;
  logic [1:0]       imem_byte_enable;
  logic [WIDTH-1:0] imem_rdata;
  logic             imem_resp;

  logic [WIDTH-1:0] mem_address;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_read;
  logic             mem_write;
  logic [1:0]       mem_byte_enable;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_resp;

  logic [WIDTH-1:0] pmem_address;
  logic [WIDTH-1:0] pmem_wdata;
  logic             pmem_read;
  logic             pmem_write;
  logic [1:0]       pmem_byte_enable;
  logic [WIDTH-1:0] pmem_rdata;
  logic             pmem_resp;

  modport slave (
    input  imem_address, imem_wdata, imem_read, imem_write, imem_byte_enable,
    output imem_rdata, imem_resp,
    input  mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable,
    output mem_rdata, mem_resp,
    output pmem_address, pmem_wdata, pmem_read, pmem_write, pmem_byte_enable,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output imem_address, imem_wdata, imem_read, imem_write, imem_byte_enable,
    input  imem_rdata, imem_resp,
    output mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable,
    input  mem_rdata, mem_resp,
    input  pmem_address, pmem_wdata, pmem_read, pmem_write, pmem_byte_enable,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) to single downstream memory arbiter with round-robin
// tie-breaking and a one-cycle recovery gap after every completed transaction.
module mem_arbiter #(
  parameter int WIDTH = 16
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   last_grant_d_q;  // 1: data port was granted most recently
  logic   i_pend, d_pend;

  assign i_pend = bus.imem_read | bus.imem_write;
  assign d_pend = bus.mem_read  | bus.mem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      last_grant_d_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == GRANT_I) last_grant_d_q <= 1'b0;
      if (state_q == IDLE && state_d == GRANT_D) last_grant_d_q <= 1'b1;
    end
  end

  always_comb begin
    state_d              = state_q;
    bus.pmem_address     = {WIDTH{1'b0}};
    bus.pmem_wdata       = {WIDTH{1'b0}};
    bus.pmem_byte_enable = 2'b00;
    bus.pmem_read        = 1'b0;
    bus.pmem_write       = 1'b0;
    bus.imem_rdata       = {WIDTH{1'b0}};
    bus.imem_resp        = 1'b0;
    bus.mem_rdata        = {WIDTH{1'b0}};
    bus.mem_resp         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_pend && d_pend) state_d = last_grant_d_q ? GRANT_I : GRANT_D;
        else if (i_pend)      state_d = GRANT_I;
        else if (d_pend)      state_d = GRANT_D;
      end
      GRANT_I: begin
        // A write strobe suppresses a simultaneous read.
        bus.pmem_address     = bus.imem_address;
        bus.pmem_wdata       = bus.imem_wdata;
        bus.pmem_byte_enable = bus.imem_byte_enable;
        bus.pmem_write       = bus.imem_write;
        bus.pmem_read        = bus.imem_read & ~bus.imem_write;
        bus.imem_rdata       = bus.pmem_rdata;
        bus.imem_resp        = bus.pmem_resp;
        if (bus.pmem_resp) state_d = RECOVER;
      end
      GRANT_D: begin
        bus.pmem_address     = bus.mem_address;
        bus.pmem_wdata       = bus.mem_wdata;
        bus.pmem_byte_enable = bus.mem_byte_enable;
        bus.pmem_write       = bus.mem_write;
        bus.pmem_read        = bus.mem_read & ~bus.mem_write;
        bus.mem_rdata        = bus.pmem_rdata;
        bus.mem_resp         = bus.pmem_resp;
        if (bus.pmem_resp) state_d = RECOVER;
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single grants, tie-breaking, alternation,
// write-over-read priority, reset mid-transaction and stray downstream responses.
module tb_mem_arbiter;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mem_arbiter_if #(.WIDTH(16)) bus ();

  mem_arbiter #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr();
    bus.imem_address = '0; bus.imem_wdata = '0; bus.imem_read = 0; bus.imem_write = 0;
    bus.imem_byte_enable = 2'b00;
    bus.mem_address = '0; bus.mem_wdata = '0; bus.mem_read = 0; bus.mem_write = 0;
    bus.mem_byte_enable = 2'b00;
    bus.pmem_rdata = '0; bus.pmem_resp = 0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    clr();
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("rst_pmem_read", {15'd0, bus.pmem_read}, 16'd0);
    chk("rst_pmem_write", {15'd0, bus.pmem_write}, 16'd0);
    chk("rst_imem_resp", {15'd0, bus.imem_resp}, 16'd0);
    chk("rst_mem_resp", {15'd0, bus.mem_resp}, 16'd0);
    chk("rst_pmem_addr", bus.pmem_address, 16'h0000);

    // V-1: single instruction read with a 3-cycle downstream latency
    bus.imem_read = 1; bus.imem_address = 16'h0040;
    settle();
    chk("v1_idle_no_read", {15'd0, bus.pmem_read}, 16'd0);
    tick();
    chk("v1_pmem_read", {15'd0, bus.pmem_read}, 16'd1);
    chk("v1_pmem_addr", bus.pmem_address, 16'h0040);
    tick();
    tick();
    chk("v1_wait_imem_resp", {15'd0, bus.imem_resp}, 16'd0);
    chk("v1_wait_pmem_read", {15'd0, bus.pmem_read}, 16'd1);
    bus.pmem_resp = 1; bus.pmem_rdata = 16'h1234;
    settle();
    chk("v1_imem_resp", {15'd0, bus.imem_resp}, 16'd1);
    chk("v1_imem_rdata", bus.imem_rdata, 16'h1234);
    chk("v1_mem_resp", {15'd0, bus.mem_resp}, 16'd0);
    chk("v1_mem_rdata", bus.mem_rdata, 16'h0000);
    tick();
    clr();
    settle();
    chk("v1_recover_resp", {15'd0, bus.imem_resp}, 16'd0);
    chk("v1_recover_read", {15'd0, bus.pmem_read}, 16'd0);
    tick();
    chk("v1_idle_read", {15'd0, bus.pmem_read}, 16'd0);

    // V-2: simultaneous requests after reset; instruction port wins the first tie
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.imem_read = 1; bus.imem_address = 16'h0100;
    bus.mem_write = 1; bus.mem_address = 16'h2000; bus.mem_wdata = 16'hBEEF;
    bus.mem_byte_enable = 2'b11;
    settle();
    chk("v2_idle_write", {15'd0, bus.pmem_write}, 16'd0);
    tick();
    chk("v2_first_read", {15'd0, bus.pmem_read}, 16'd1);
    chk("v2_first_write", {15'd0, bus.pmem_write}, 16'd0);
    chk("v2_first_addr", bus.pmem_address, 16'h0100);
    bus.pmem_resp = 1; bus.pmem_rdata = 16'h5555;
    settle();
    chk("v2_imem_resp", {15'd0, bus.imem_resp}, 16'd1);
    chk("v2_mem_resp_quiet", {15'd0, bus.mem_resp}, 16'd0);
    tick();
    bus.imem_read = 0; bus.pmem_resp = 0;
    settle();
    chk("v2_recover_write", {15'd0, bus.pmem_write}, 16'd0);
    tick();
    chk("v2_idle_write2", {15'd0, bus.pmem_write}, 16'd0);
    tick();
    chk("v2_pmem_write", {15'd0, bus.pmem_write}, 16'd1);
    chk("v2_pmem_read", {15'd0, bus.pmem_read}, 16'd0);
    chk("v2_pmem_addr", bus.pmem_address, 16'h2000);
    chk("v2_pmem_wdata", bus.pmem_wdata, 16'hBEEF);
    chk("v2_pmem_be", {14'd0, bus.pmem_byte_enable}, 16'd3);
    bus.pmem_resp = 1;
    settle();
    chk("v2_mem_resp", {15'd0, bus.mem_resp}, 16'd1);
    chk("v2_imem_resp_quiet", {15'd0, bus.imem_resp}, 16'd0);
    tick();
    clr();
    tick();

    // V-3: both ports continuously pending; grants alternate starting with I
    bus.imem_read = 1; bus.imem_address = 16'h0A00;
    bus.mem_read = 1;  bus.mem_address = 16'h0D00;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("v3_addr_%0d", k), bus.pmem_address, (k % 2 == 0) ? 16'h0A00 : 16'h0D00);
      bus.pmem_resp = 1; bus.pmem_rdata = 16'h0F00 + 16'(k);
      settle();
      chk($sformatf("v3_iresp_%0d", k), {15'd0, bus.imem_resp}, (k % 2 == 0) ? 16'd1 : 16'd0);
      chk($sformatf("v3_dresp_%0d", k), {15'd0, bus.mem_resp}, (k % 2 == 0) ? 16'd0 : 16'd1);
      chk($sformatf("v3_excl_%0d", k), {15'd0, bus.imem_resp & bus.mem_resp}, 16'd0);
      tick();
      bus.pmem_resp = 0;
      tick();
    end
    clr();
    tick();

    // V-4: read and write together on the data port; the write wins
    bus.mem_read = 1; bus.mem_write = 1; bus.mem_address = 16'h3000;
    tick();
    chk("v4_pmem_write", {15'd0, bus.pmem_write}, 16'd1);
    chk("v4_pmem_read", {15'd0, bus.pmem_read}, 16'd0);
    chk("v4_pmem_addr", bus.pmem_address, 16'h3000);
    bus.pmem_resp = 1;
    settle();
    tick();
    clr();
    tick();

    // V-5: reset while the data port is granted; the late response is dropped
    bus.mem_write = 1; bus.mem_address = 16'h4000;
    tick();
    chk("v5_granted", {15'd0, bus.pmem_write}, 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.mem_write = 0;
    bus.pmem_resp = 1;
    settle();
    chk("v5_write_after_rst", {15'd0, bus.pmem_write}, 16'd0);
    chk("v5_mem_resp", {15'd0, bus.mem_resp}, 16'd0);
    tick();
    bus.pmem_resp = 0;
    settle();
    chk("v5_mem_resp_later", {15'd0, bus.mem_resp}, 16'd0);

    // V-6: stray downstream response with nothing pending stays in IDLE
    bus.pmem_resp = 1;
    settle();
    chk("v6_imem_resp", {15'd0, bus.imem_resp}, 16'd0);
    chk("v6_mem_resp", {15'd0, bus.mem_resp}, 16'd0);
    tick();
    bus.pmem_resp = 0;
    bus.imem_read = 1; bus.imem_address = 16'h0050;
    tick();
    chk("v6_prompt_grant", {15'd0, bus.pmem_read}, 16'd1);
    chk("v6_grant_addr", bus.pmem_address, 16'h0050);

    // Granted port withdraws its strobe, then a late response still completes it
    bus.imem_read = 0;
    settle();
    chk("drop_mirror_read", {15'd0, bus.pmem_read}, 16'd0);
    tick();
    bus.pmem_resp = 1; bus.pmem_rdata = 16'hCAFE;
    settle();
    chk("late_imem_resp", {15'd0, bus.imem_resp}, 16'd1);
    chk("late_imem_rdata", bus.imem_rdata, 16'hCAFE);
    tick();
    clr();
    bus.mem_read = 1; bus.mem_address = 16'h0777;
    settle();
    chk("late_recover_read", {15'd0, bus.pmem_read}, 16'd0);
    tick();
    chk("late_idle_read", {15'd0, bus.pmem_read}, 16'd0);
    tick();
    chk("late_next_grant", {15'd0, bus.pmem_read}, 16'd1);
    chk("late_next_addr", bus.pmem_address, 16'h0777);
    clr();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WIDTH, default 16, address/data width of all ports.
REQ-002 clk  in  1  rising-edge clock; sole clock.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 imem_address  in  WIDTH  instruction-port byte address.
REQ-005 imem_wdata  in  WIDTH  instruction-port write data.
REQ-006 imem_read / imem_write  in  1 each  instruction-port request strobes, held until imem_resp.
REQ-007 imem_byte_enable  in  2  instruction-port byte lanes.
REQ-008 imem_rdata  out  WIDTH  instruction-port read data.
REQ-009 imem_resp  out  1  instruction-port completion pulse.
REQ-010 mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable  in  WIDTH/WIDTH/1/1/2  data-port request, same semantics as REQ-004..007.
REQ-011 mem_rdata  out  WIDTH;  mem_resp  out  1  data-port read data and completion pulse.
REQ-012 pmem_address, pmem_wdata  out  WIDTH  downstream (L2) request address/data.
REQ-013 pmem_read, pmem_write  out  1;  pmem_byte_enable  out  2  downstream strobes and lanes.
REQ-014 pmem_rdata  in  WIDTH;  pmem_resp  in  1  downstream read data and completion pulse.

Function
REQ-015 States SHALL be IDLE, GRANT_I, GRANT_D, RECOVER; one-hot or encoded is free.
REQ-016 Pending: port pending when its read or write is high; if both strobes high, write SHALL win and read is ignored.
REQ-017 IDLE: only I pending -> GRANT_I; only D pending -> GRANT_D; both -> port not most recently granted; none -> stay IDLE.
REQ-018 last_grant register SHALL update on every entry to GRANT_I/GRANT_D; reset value D, so I wins the first tie after reset.
REQ-019 In IDLE and RECOVER all pmem strobes SHALL be 0; address/wdata/byte_enable SHALL be 0.
REQ-020 In GRANT_x, pmem_address/wdata/byte_enable/read/write SHALL combinationally mirror port x inputs; other port's inputs ignored.
REQ-021 Granted port SHALL see x_resp = pmem_resp and x_rdata = pmem_rdata in the same cycle; non-granted port resp = 0, rdata = 0.
REQ-022 GRANT_x -> RECOVER on the cycle pmem_resp = 1; otherwise stay (no timeout).
REQ-023 RECOVER SHALL last exactly one cycle, then IDLE; requests seen in RECOVER are not granted until IDLE evaluates them.
REQ-024 Minimum per-request latency: 1 cycle IDLE decision, then request issued; back-to-back requests on one port SHALL be separated by at least 2 idle cycles on pmem (RECOVER + IDLE).
REQ-025 If granted port drops its strobes before pmem_resp, arbiter SHALL stay in GRANT_x and deassert pmem strobes per REQ-020 (mirror); a late pmem_resp still moves to RECOVER and pulses x_resp.
REQ-026 pmem_resp arriving in IDLE or RECOVER SHALL be ignored: no port resp, no state change.
REQ-027 imem_resp and mem_resp SHALL never be high in the same cycle.

Reset
REQ-028 rst sampled high at a clock edge SHALL force IDLE and last_grant = D on that edge; all pmem strobes and both resp outputs 0 from the following cycle.
REQ-029 Reset mid-transaction SHALL abandon it; pmem_resp from the abandoned request is dropped per REQ-026.

Verification
V-1 Reset, then imem_read=1 addr 0x0040; pmem_rdata=0x1234, pmem_resp after 3 cycles -> pmem_read=1 addr 0x0040, imem_resp pulse 1 cycle, imem_rdata=0x1234, mem_resp=0.
V-2 Reset, imem_read and mem_write (addr 0x2000, wdata 0xBEEF, be 2'b11) raised same cycle -> I granted first; after RECOVER+IDLE, pmem_write=1 addr 0x2000 wdata 0xBEEF.
V-3 Both ports continuously pending for 6 transactions -> grants alternate I,D,I,D,I,D; resp never simultaneous.
V-4 mem_read and mem_write both high, addr 0x3000 -> pmem_write=1, pmem_read=0.
V-5 rst asserted while in GRANT_D with pmem_resp due next cycle -> strobes 0 after reset edge, pmem_resp ignored, mem_resp stays 0.
V-6 pmem_resp pulsed with no request pending -> state stays IDLE, both resp 0.
